// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the counter-width helper.
package mdu_pkg;

  // Code 7 is a move-from; mf_sel_i picks LO (1) or HI (0).
  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpMf    = 3'd7
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic int unsigned cnt_width(int unsigned mult_c, int unsigned div_c);
    return $clog2(((mult_c > div_c) ? mult_c : div_c) + 1);
  endfunction

  function automatic logic is_arith(mdu_op_e op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
// Produces the HI/LO pair and flags divide-by-zero so the caller can skip the write.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic        [63:0] prod;
  logic        [63:0] a_ext;
  logic        [63:0] b_ext;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic               is_signed;
  logic               div_ovf;

  assign is_signed = (op_i == OpMult);
  assign a_ext     = is_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign b_ext     = is_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  // Truncated 64x64 product equals the exact 32x32 result for both signednesses.
  assign prod      = a_ext * b_ext;

  assign a_s     = a_i;
  assign b_s     = b_i;
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign q_s     = (b_i == 32'd0 || div_ovf) ? 32'sd0 : a_s / b_s;
  assign r_s     = (b_i == 32'd0 || div_ovf) ? 32'sd0 : a_s % b_s;

  always_comb begin
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    div_zero_o = 1'b0;
    unique case (op_i)
      OpMult, OpMultu: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      OpDiv: begin
        div_zero_o = (b_i == 32'd0);
        if (div_ovf) begin
          hi_o = 32'd0;
          lo_o = 32'h8000_0000;
        end else begin
          hi_o = r_s;
          lo_o = q_s;
        end
      end
      OpDivu: begin
        div_zero_o = (b_i == 32'd0);
        if (b_i != 32'd0) begin
          hi_o = a_i % b_i;
          lo_o = a_i / b_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: latches operands, counts fixed latency,
// drives busy and owns the HI/LO architectural registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  mdu_op_i,
  input  logic        mf_sel_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        req_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o
);

  localparam int unsigned CntW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  mdu_op_e     op_in;
  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  assign op_in = mdu_op_e'(mdu_op_i);

  mdu_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .hi_o       (res_hi),
    .lo_o       (res_lo),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (!req_i) begin
          if (start_i && is_arith(op_in)) begin
            op_d    = op_in;
            a_d     = rs_data_i;
            b_d     = rt_data_i;
            cnt_d   = (op_in == OpMult || op_in == OpMultu) ? CntW'(MULT_CYCLES)
                                                            : CntW'(DIV_CYCLES);
            state_d = StRun;
          end else if (op_in == OpMthi) begin
            hi_d = rs_data_i;
          end else if (op_in == OpMtlo) begin
            lo_d = rs_data_i;
          end
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (!div_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == StRun);
    hi_o      = hi_q;
    lo_o      = lo_q;
    mf_data_o = (op_in == OpMf) ? (mf_sel_i ? lo_q : hi_q) : 32'd0;
  end

  // The stall unit must keep new issues and HI/LO moves out of E while busy.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == StRun && !req_i) begin
      assert (!(start_i && is_arith(op_in)) && op_in != OpMthi && op_in != OpMtlo);
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic results, HI/LO moves,
// flush suppression, back-to-back issue and asynchronous reset.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mdu_op;
  logic        mf_sel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int checks   = 0;
  int failures = 0;
  int n;

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .mdu_op_i  (mdu_op),
    .mf_sel_i  (mf_sel),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .req_i     (req),
    .busy_o    (busy),
    .hi_o      (hi),
    .lo_o      (lo),
    .mf_data_o (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present the op for one posedge, return at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    start   = st;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    req     = rq;
    @(negedge clk);
    start   = 1'b0;
    mdu_op  = OpNone;
    rs_data = 32'd0;
    rt_data = 32'd0;
    req     = 1'b0;
  endtask

  // Counts busy negedges starting from the current one, bounded at 100.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mdu_op = OpNone; mf_sel = 1'b0;
    rs_data = '0; rt_data = '0; req = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_mf", mf_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MULT -3 * 5
    issue(OpMult, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    wait_done(n);
    check("mult_lat", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // DIVU 17 / 5
    issue(OpDivu, 32'd17, 32'd5, 1'b1, 1'b0);
    wait_done(n);
    check("divu_lat", n, 32'd10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd2);

    // DIV -7 / 2
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done(n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // MTHI / MTLO, then divide by zero leaves them alone
    issue(OpMthi, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OpMtlo, 32'h5678, 32'd0, 1'b0, 1'b0);
    check("mtlo_lo", lo, 32'h5678);
    issue(OpDiv, 32'd99, 32'd0, 1'b1, 1'b0);
    wait_done(n);
    check("div0_lat", n, 32'd10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);
    mdu_op = OpMf; mf_sel = 1'b0;
    #1 check("mfhi", mf_data, 32'h1234);
    mf_sel = 1'b1;
    #1 check("mflo", mf_data, 32'h5678);
    mdu_op = OpNone; mf_sel = 1'b0;
    #1 check("mf_none", mf_data, 32'd0);
    @(negedge clk);

    // Flushed issue and flushed move do nothing
    issue(OpMult, 32'd3, 32'd4, 1'b1, 1'b1);
    check("req_busy", {31'd0, busy}, 32'd0);
    issue(OpMthi, 32'hDEAD, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("req_hi", hi, 32'h1234);
    check("req_lo", lo, 32'h5678);

    // req pulse during RUN does not disturb the op
    issue(OpDiv, 32'd100, 32'd7, 1'b1, 1'b0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done(n);
    check("divreq_lat", n + 1, 32'd10);
    check("divreq_lo", lo, 32'd14);
    check("divreq_hi", hi, 32'd2);

    // MULTU max*max, then back-to-back issue on the cycle busy falls
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    issue(OpMult, 32'd6, 32'd7, 1'b1, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("b2b_lat", n, 32'd5);
    check("b2b_lo", lo, 32'd42);
    check("b2b_hi", hi, 32'd0);

    // Signed overflow case
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // Async reset in the middle of a DIV
    issue(OpDiv, 32'd50, 32'd3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_hi", hi, 32'd0);
    check("post_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the E-stage multiply/divide unit. It accepts one mult/div or HI/LO move per cycle from E, latches operands, and counts the fixed operation latency. It drives busy to the hazard/stall logic and owns the HI/LO architectural registers. It suppresses issue when an exception/interrupt request flushes the E-stage instruction.

Parameters:
MULT_CYCLES, 5, busy duration of mult/multu in cycles (>=1)
DIV_CYCLES, 10, busy duration of div/divu in cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage instruction is mult/multu/div/divu this cycle
mdu_op  input  3  operation select (encodings in package)
rs_data  input  32  forwarded rs operand (E stage)
rt_data  input  32  forwarded rt operand (E stage)
req  input  1  exception/interrupt flush of E-stage instruction; blocks issue this cycle
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register
mf_data  output  32  mfhi ? hi : mflo ? lo : 0 (combinational)

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0; an in-flight op is discarded.
- States: IDLE, RUN.
- IDLE, start=1, req=0, mdu_op in {MULT,MULTU,DIV,DIVU}: latch rs_data, rt_data, op; counter loads MULT_CYCLES or DIV_CYCLES; go RUN.
- RUN: busy=1; counter decrements each cycle. When counter==1: write result to hi/lo at that edge, go IDLE, busy=0 next cycle.
- Timing: start sampled at edge t -> busy=1 for exactly LAT cycles, then new hi/lo visible and busy=0 in the same cycle.
- Arithmetic, from latched operands:
  - MULT: signed 32x32 -> 64; hi=upper, lo=lower.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero: hi/lo unchanged; busy still asserted for DIV_CYCLES.
- MTHI/MTLO, req=0, IDLE: hi (resp. lo) <= rs_data at the next edge. No busy. Does not require the start signal; decoded from mdu_op alone.
- req=1: no issue, no MTHI/MTLO write that cycle. An op already in RUN is not affected and completes normally.
- start or MTHI/MTLO while RUN: ignored. The stall unit prevents this; a simulation assertion flags it.
- MFHI/MFLO: mf_data is combinational from the current hi/lo. The stall unit holds these instructions in D while busy.
- mdu_op = NONE, or an unlisted encoding: no action.

Decomposition:
- Shared package mdu_pkg:
  - 3-bit op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI/MFLO=7 with a separate select bit, or an extended encoding chosen once in the package.
  - State encoding IDLE/RUN.
  - Counter width: $clog2 of max(MULT_CYCLES, DIV_CYCLES)+1.
- Sub-module mdu_arith (combinational):
  - Inputs: latched operands and op.
  - Outputs: {hi_res, lo_res} and div_zero.
  - Keeps the FSM and counter in mdu_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5, start=1 one cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- DIVU rs=17, rt=5 -> busy 10 cycles; then lo=3, hi=2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload with MTHI 0x1234, MTLO 0x5678, then DIV rt=0 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged. MFHI gives mf_data=0x1234.
- start=1 (MULT) with req=1 in the same cycle -> busy stays 0, hi/lo unchanged. Then req pulse during RUN of a DIV -> completes at cycle 10 with the correct result.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start on the cycle busy falls -> new op accepted, busy re-asserts next cycle.
- Assert reset asynchronously mid-way through a DIV (cycle 4) -> busy, hi, lo = 0 immediately without waiting for clk. After release, no completion write occurs.
